// File: rtl/stack.sv
// stack: synchronous LIFO of `size` direction codes with a registered pop
// output. Callers push codes while exploring and pop them in reverse order
// while backtracking. Requests that would overflow or underflow are dropped.
module stack #(
   parameter int direction_length = 2,
   parameter int size             = 256
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic                        pop,
   input  logic [direction_length-1:0] data_in,
   output logic [direction_length-1:0] data_out,
   output logic                        empty
);

   localparam int count_width = $clog2(size + 1);
   localparam int addr_width  = $clog2(size);
   localparam logic [count_width-1:0] count_one = count_width'(1);
   localparam logic [count_width-1:0] count_max = count_width'(size);

   typedef logic [direction_length-1:0] entry_t;

   entry_t                 mem [size];
   logic [count_width-1:0] count;
   logic [count_width-1:0] count_minus_one;
   logic [addr_width-1:0]  wr_addr;
   logic [addr_width-1:0]  top_addr;
   logic                   full;
   logic                   do_push;
   logic                   do_pop;
   logic                   do_replace;
   logic                   mem_we;
   logic [addr_width-1:0]  mem_addr;

   // Decode the accepted operation for this cycle; push+pop on an empty
   // stack degrades to a plain push, push+pop otherwise replaces the top.
   always_comb begin
      empty           = (count == '0);
      full            = (count == count_max);
      count_minus_one = count - count_one;
      wr_addr         = count[addr_width-1:0];
      top_addr        = count_minus_one[addr_width-1:0];
      do_push         = push && (pop ? empty : !full);
      do_pop          = pop && !push && !empty;
      do_replace      = push && pop && !empty;
      mem_we          = do_push || do_replace;
      mem_addr        = do_replace ? top_addr : wr_addr;
   end

   // Storage array: single write port, no reset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= data_in;
      end
   end

   // Occupancy counter and registered read of the old top on pop/replace.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count    <= '0;
         data_out <= '0;
      end else begin
         if (do_pop || do_replace) begin
            data_out <= mem[top_addr];
         end
         if (do_push) begin
            count <= count + count_one;
         end else if (do_pop) begin
            count <= count_minus_one;
         end
      end
   end

endmodule

// File: tb/tb_stack.sv
// tb_stack: scoreboard bench for stack. The driver applies operations and
// queues the expected data_out/empty from a queue-based LIFO model; the
// monitor pops and compares each expectation as it is announced.
module tb_stack;

   localparam int DW   = 2;
   localparam int SIZE = 256;

   logic          clk;
   logic          rst;
   logic          push;
   logic          pop;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;
   logic          empty;

   stack #(.direction_length(DW), .size(SIZE)) dut (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .data_in  (data_in),
      .data_out (data_out),
      .empty    (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string         name;
      logic [DW-1:0] exp_out;
      logic          exp_empty;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] model_q[$];
   logic [DW-1:0] model_out;
   int            errors = 0;
   int            checks = 0;
   int            txn    = 0;
   event          chk_ev;

   // Monitor: compare every announced expectation against the DUT outputs.
   initial begin
      forever begin
         @(chk_ev);
         while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            txn++;
            checks++;
            if (data_out !== e.exp_out) begin
               errors++;
               $display("FAIL %s data_out: got %0d expected %0d", e.name, data_out, e.exp_out);
            end
            checks++;
            if (empty !== e.exp_empty) begin
               errors++;
               $display("FAIL %s empty: got %0d expected %0d", e.name, empty, e.exp_empty);
            end
            $display("txn %0d %s: data_out=%0d empty=%0d", txn, e.name, data_out, empty);
         end
      end
   end

   task automatic expect_now(input string name);
      exp_t e;
      e.name      = name;
      e.exp_out   = model_out;
      e.exp_empty = (model_q.size() == 0);
      exp_q.push_back(e);
      -> chk_ev;
   endtask

   // Apply one operation for one clock edge, update the LIFO model, and
   // announce the expected post-edge outputs.
   task automatic do_op(input logic p, input logic q, input logic [DW-1:0] d, input string name);
      push    = p;
      pop     = q;
      data_in = d;
      if (p && q) begin
         if (model_q.size() == 0) begin
            model_q.push_back(d);
         end else begin
            model_out = model_q.pop_back();
            model_q.push_back(d);
         end
      end else if (p) begin
         if (model_q.size() < SIZE) model_q.push_back(d);
      end else if (q) begin
         if (model_q.size() > 0) model_out = model_q.pop_back();
      end
      @(posedge clk);
      #1;
      expect_now(name);
   endtask

   initial begin
      rst     = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      data_in = '0;
      model_out = '0;

      // Reset state
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      expect_now("reset");

      // Push three, idle, pop three, pop on empty
      do_op(1, 0, 2'd1, "push01");
      do_op(1, 0, 2'd2, "push10");
      do_op(1, 0, 2'd3, "push11");
      do_op(0, 0, 2'd0, "idle");
      do_op(0, 1, 2'd0, "pop_a");
      do_op(0, 1, 2'd0, "pop_b");
      do_op(0, 1, 2'd0, "pop_c");
      do_op(0, 1, 2'd0, "pop_empty");

      // Fill to capacity, extra push dropped, drain completely
      for (int i = 0; i < SIZE; i++) do_op(1, 0, DW'(i % 4), "fill");
      do_op(1, 0, 2'd3, "push_full");
      for (int i = 0; i < SIZE; i++) do_op(0, 1, 2'd0, "drain");
      do_op(0, 1, 2'd0, "drain_empty");

      // Simultaneous push and pop replaces the top
      do_op(1, 0, 2'd1, "sim_push01");
      do_op(1, 0, 2'd2, "sim_push10");
      do_op(1, 1, 2'd3, "sim_replace");
      do_op(0, 1, 2'd0, "sim_pop1");
      do_op(0, 1, 2'd0, "sim_pop2");
      do_op(0, 1, 2'd0, "sim_pop_empty");
      do_op(1, 1, 2'd2, "sim_on_empty");
      do_op(0, 1, 2'd0, "sim_on_empty_pop");

      // Asynchronous reset between clock edges
      do_op(1, 0, 2'd3, "ar_push1");
      do_op(1, 0, 2'd1, "ar_push2");
      do_op(0, 1, 2'd0, "ar_pop");
      push = 1'b0;
      pop  = 1'b0;
      #2;
      rst = 1'b0;
      model_q.delete();
      model_out = '0;
      #1;
      expect_now("async_reset");
      @(negedge clk);
      rst = 1'b1;
      do_op(0, 1, 2'd0, "pop_after_reset");

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         logic p;
         logic q;
         p = ($urandom_range(0, 99) < 55);
         q = ($urandom_range(0, 99) < 45);
         do_op(p, q, DW'($urandom), "rand");
      end

      push = 1'b0;
      pop  = 1'b0;
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
